// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus controller: round-robin arbitration of cache requests,
// snoop broadcast, and cache-to-cache / memory data return over one memory port.
module coherence_bus_ctrl #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          ccif_dREN,
    input  logic [CPUS-1:0]          ccif_dWEN,
    input  logic [CPUS*WORD_W-1:0]   ccif_daddr,
    input  logic [CPUS*WORD_W-1:0]   ccif_dstore,
    input  logic [CPUS-1:0]          ccif_cctrans,
    input  logic [CPUS-1:0]          ccif_ccwrite,
    output logic [CPUS-1:0]          ccif_dwait,
    output logic [CPUS*WORD_W-1:0]   ccif_dload,
    output logic [CPUS-1:0]          ccif_ccwait,
    output logic [CPUS-1:0]          ccif_ccinv,
    output logic [CPUS*WORD_W-1:0]   ccif_ccsnoopaddr,
    input  logic                     dwait,
    input  logic [WORD_W-1:0]        dload,
    output logic                     dREN,
    output logic                     dWEN,
    output logic [WORD_W-1:0]        daddr,
    output logic [WORD_W-1:0]        dstore
);

    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        MEMRD,
        C2C,
        MEMWR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   r_q, r_d;
    logic [IDX_W-1:0]   p_q, p_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [CPUS-1:0]    req;
    logic [CPUS-1:0]    r_oh;
    logic               win_found;
    logic [IDX_W-1:0]   win;
    logic               sup_found;
    logic [IDX_W-1:0]   sup;
    logic               all_ack;
    logic [IDX_W-1:0]   ptr_next;
    logic [WORD_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_store;
    logic [WORD_W-1:0]  p_store;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            r_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            r_q     <= r_d;
            p_q     <= p_d;
        end
    end

    // Request decode, rotating winner search and lowest-index Modified supplier.
    always_comb begin
        req       = ccif_dREN | ccif_dWEN | (ccif_cctrans & ccif_ccwrite);
        r_oh      = CPUS'(1) << r_q;
        all_ack   = &(ccif_cctrans | r_oh);
        ptr_next  = IDX_W'((int'(r_q) + 1) % CPUS);
        r_addr    = ccif_daddr[int'(r_q)*WORD_W +: WORD_W];
        r_store   = ccif_dstore[int'(r_q)*WORD_W +: WORD_W];
        p_store   = ccif_dstore[int'(p_q)*WORD_W +: WORD_W];
        win_found = 1'b0;
        win       = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (!win_found && req[(int'(ptr_q) + k) % CPUS]) begin
                win_found = 1'b1;
                win       = IDX_W'((int'(ptr_q) + k) % CPUS);
            end
        end
        sup_found = 1'b0;
        sup       = '0;
        for (int s = 0; s < CPUS; s++) begin
            if (!sup_found && (s != int'(r_q)) && ccif_ccwrite[s]) begin
                sup_found = 1'b1;
                sup       = IDX_W'(s);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        r_d              = r_q;
        p_d              = p_q;
        ptr_d            = ptr_q;
        ccif_dwait       = '1;
        ccif_dload       = '0;
        ccif_ccwait      = '0;
        ccif_ccinv       = '0;
        ccif_ccsnoopaddr = '0;
        dREN             = 1'b0;
        dWEN             = 1'b0;
        daddr            = '0;
        dstore           = '0;

        // Outputs are held at their reset values while RST is high so an
        // abandoned transaction cannot touch memory in the reset cycle.
        if (!RST) begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        r_d = win;
                        if (ccif_dREN[win] || (ccif_cctrans[win] && ccif_ccwrite[win])) begin
                            state_d = SNOOP;
                        end else begin
                            state_d = MEMWR;
                        end
                    end
                end

                SNOOP: begin
                    for (int s = 0; s < CPUS; s++) begin
                        if (s != int'(r_q)) begin
                            ccif_ccwait[s]                         = 1'b1;
                            ccif_ccinv[s]                          = ccif_ccwrite[r_q];
                            ccif_ccsnoopaddr[s*WORD_W +: WORD_W]   = r_addr;
                        end
                    end
                    if (all_ack) begin
                        if (!ccif_dREN[r_q]) begin
                            ccif_dwait[r_q] = 1'b0;
                            ptr_d           = ptr_next;
                            state_d         = IDLE;
                        end else if (sup_found) begin
                            p_d     = sup;
                            state_d = C2C;
                        end else begin
                            state_d = MEMRD;
                        end
                    end
                end

                MEMRD: begin
                    dREN                                   = 1'b1;
                    daddr                                  = r_addr;
                    ccif_dload[int'(r_q)*WORD_W +: WORD_W] = dload;
                    ccif_dwait[r_q]                        = dwait;
                    if (!dwait) begin
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end
                end

                // Supplier data goes to the requester and to memory in one transfer.
                C2C: begin
                    ccif_ccwait[p_q]                       = 1'b1;
                    dWEN                                   = 1'b1;
                    daddr                                  = r_addr;
                    dstore                                 = p_store;
                    ccif_dload[int'(r_q)*WORD_W +: WORD_W] = p_store;
                    ccif_dwait[r_q]                        = dwait;
                    ccif_dwait[p_q]                        = dwait;
                    if (!dwait) begin
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end
                end

                MEMWR: begin
                    dWEN            = 1'b1;
                    daddr           = r_addr;
                    dstore          = r_store;
                    ccif_dwait[r_q] = dwait;
                    if (!dwait) begin
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
